pcm_to_i2s_tx: RTL



---
 rtl/pcm_to_i2s_tx_pkg.sv | 31 +++
 rtl/pcm_to_i2s_tx_shifter.sv | 45 ++++
 rtl/pcm_to_i2s_tx.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/pcm_to_i2s_tx_pkg.sv
// Shared project parameters for the I2S transmit output stage.
// Latency: n/a (constants, types and small helpers only).
// Backpressure: n/a.
//
// Contents:
//   NUMBER_OF_BITS : PCM sample width per channel
//   SLOT_BITS      : clk cycles per WS half-period (must exceed NUMBER_OF_BITS)
//   state_t        : transmit FSM state encoding
//   CNT_W          : slot counter width
package pcm_to_i2s_tx_pkg;

    localparam int NUMBER_OF_BITS = 8;
    localparam int SLOT_BITS      = 16;

    // Slot counter must hold 0..SLOT_BITS-1.
    localparam int CNT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LEFT  = 2'b01,
        RIGHT = 2'b10
    } state_t;

    // True when a slot count falls inside the data window 1..NUMBER_OF_BITS.
    // Count 0 is the one-bit delay after the WS edge; counts beyond the
    // sample width are padding.
    function automatic logic in_data_window(input logic [CNT_W-1:0] cnt);
        return (cnt >= CNT_W'(1)) && (cnt <= CNT_W'(NUMBER_OF_BITS));
    endfunction

endpackage

// File: rtl/pcm_to_i2s_tx_shifter.sv
// Per-channel MSB-first serialiser for one PCM word.
// Latency: the first data bit appears one cycle after the first i_shift following a load.
// Backpressure: none; it shifts whenever the parent asserts i_shift.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   i_load     : capture i_word; the serial output is 0 in the load cycle
//   i_word     : word to serialise
//   i_shift    : emit the current MSB on the next edge and advance
//   o_sd       : registered serial bit, 0 whenever not shifting
module pcm_to_i2s_tx_shifter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_word,
    input  logic         i_shift,
    output logic         o_sd
);

    logic [W-1:0] r_sr;
    logic         r_sd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
            r_sd <= 1'b0;
        end else if (i_load) begin
            // Load cycle is the delay bit slot, so the line stays low.
            r_sr <= i_word;
            r_sd <= 1'b0;
        end else if (i_shift) begin
            r_sd <= r_sr[W-1];
            r_sr <= r_sr << 1;
        end else begin
            // Outside the data window the line is held low; this also lets
            // the parent OR the two channel outputs together.
            r_sd <= 1'b0;
        end
    end

    assign o_sd = r_sd;

endmodule

// File: rtl/pcm_to_i2s_tx.sv
// I2S transmitter: one left/right PCM pair per frame, MSB first, one-bit delay after WS edges.
// Latency: a held pair is loaded on the edge that starts a frame; its MSB appears at slot count 1.
// Backpressure: in_ready drops while the single-pair holding register is full.
//
// Optional feature: define PCM_TX_UNDERRUN_REPEAT_EN to resend the last
// transmitted pair on underrun instead of zeros.
//
// Ports:
//   clk       : system clock, also the I2S bit clock
//   rst_n     : asynchronous active-low reset
//   en        : transmit enable, sampled in IDLE and at the end of the RIGHT slot
//   in_left   : left PCM sample
//   in_right  : right PCM sample
//   in_valid  : sample pair valid
//   in_ready  : holding register empty
//   ws        : word select, 0 = left slot, 1 = right slot
//   sd        : serial data
//   underrun  : one-cycle pulse when a frame starts with no sample held
//   busy      : FSM not IDLE
module pcm_to_i2s_tx
    import pcm_to_i2s_tx_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUMBER_OF_BITS-1:0] in_left,
    input  logic [NUMBER_OF_BITS-1:0] in_right,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic                      ws,
    output logic                      sd,
    output logic                      underrun,
    output logic                      busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_BITS - 1);

    // ------------------------------------------------------------------
    // Frame FSM and slot counter
    // ------------------------------------------------------------------
    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             w_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_load      = 1'b0;
        case (r_state)
            IDLE: begin
                w_nxt_cnt = '0;
                if (en) begin
                    w_nxt_state = LEFT;
                    w_load      = 1'b1;
                end
            end
            LEFT: begin
                if (r_cnt == CNT_LAST) begin
                    w_nxt_state = RIGHT;
                    w_nxt_cnt   = '0;
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            RIGHT: begin
                if (r_cnt == CNT_LAST) begin
                    w_nxt_cnt = '0;
                    // en only matters at the frame boundary, so a mid-frame
                    // deassertion always lets the current frame finish.
                    if (en) begin
                        w_nxt_state = LEFT;
                        w_load      = 1'b1;
                    end else begin
                        w_nxt_state = IDLE;
                    end
                end else begin
                    w_nxt_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_nxt_state = IDLE;
                w_nxt_cnt   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Single-pair holding register
    // ------------------------------------------------------------------
    logic                      r_hold_vld;
    logic [NUMBER_OF_BITS-1:0] r_hold_l;
    logic [NUMBER_OF_BITS-1:0] r_hold_r;
    logic                      w_accept;

    assign w_accept = in_valid && !r_hold_vld;
    assign in_ready = !r_hold_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld <= 1'b0;
            r_hold_l   <= '0;
            r_hold_r   <= '0;
        end else if (w_accept) begin
            // Accept implies the register was empty, so a load on this same
            // edge had nothing to take; the new pair waits for the next frame.
            r_hold_vld <= 1'b1;
            r_hold_l   <= in_left;
            r_hold_r   <= in_right;
        end else if (w_load) begin
            r_hold_vld <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Frame load source: held pair, or underrun fill
    // ------------------------------------------------------------------
    logic [NUMBER_OF_BITS-1:0] w_fill_l;
    logic [NUMBER_OF_BITS-1:0] w_fill_r;
    logic [NUMBER_OF_BITS-1:0] w_load_l;
    logic [NUMBER_OF_BITS-1:0] w_load_r;

`ifdef PCM_TX_UNDERRUN_REPEAT_EN
    logic [NUMBER_OF_BITS-1:0] r_last_l;
    logic [NUMBER_OF_BITS-1:0] r_last_r;

    // Remembers the last pair actually taken from the holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_l <= '0;
            r_last_r <= '0;
        end else if (w_load && r_hold_vld) begin
            r_last_l <= r_hold_l;
            r_last_r <= r_hold_r;
        end
    end

    assign w_fill_l = r_last_l;
    assign w_fill_r = r_last_r;
`else
    assign w_fill_l = '0;
    assign w_fill_r = '0;
`endif

    assign w_load_l = r_hold_vld ? r_hold_l : w_fill_l;
    assign w_load_r = r_hold_vld ? r_hold_r : w_fill_r;

    // ------------------------------------------------------------------
    // Serialisers. Shift decisions use the next-state count so that sd is
    // registered and lines up with the state/count it belongs to.
    // ------------------------------------------------------------------
    logic w_shift_l;
    logic w_shift_r;
    logic w_sd_l;
    logic w_sd_r;

    assign w_shift_l = (w_nxt_state == LEFT)  && in_data_window(w_nxt_cnt);
    assign w_shift_r = (w_nxt_state == RIGHT) && in_data_window(w_nxt_cnt);

    pcm_to_i2s_tx_shifter #(
        .W (NUMBER_OF_BITS)
    ) u_shift_l (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_word  (w_load_l),
        .i_shift (w_shift_l),
        .o_sd    (w_sd_l)
    );

    pcm_to_i2s_tx_shifter #(
        .W (NUMBER_OF_BITS)
    ) u_shift_r (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_word  (w_load_r),
        .i_shift (w_shift_r),
        .o_sd    (w_sd_r)
    );

    // Each shifter drives 0 outside its own data window, so an OR merges
    // them without a ws-controlled mux.
    assign sd = w_sd_l | w_sd_r;

    // ------------------------------------------------------------------
    // Registered ws and underrun
    // ------------------------------------------------------------------
    logic r_ws;
    logic r_underrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ws       <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_ws       <= (w_nxt_state == RIGHT);
            r_underrun <= w_load && !r_hold_vld;
        end
    end

    assign ws       = r_ws;
    assign underrun = r_underrun;
    assign busy     = (r_state != IDLE);

endmodule
